// File: rtl/c16_prg_loader.sv
// C16 .PRG injector: buffers the host byte stream, stalls the 8501 via WAIT,
// writes the payload into RAM in bursts and patches the BASIC end pointers.
module c16_prg_loader #(
  parameter int GUARD     = 64,
  parameter int WR_CYCLES = 4,
  parameter int BURST     = 8
) (
  input  logic        CLK28,
  input  logic        RESET,
  input  logic        dl_start,
  input  logic        dl_wr,
  input  logic [7:0]  dl_data,
  input  logic        dl_end,
  output logic        dl_ready,
  output logic        busy,
  output logic        wait_cpu,
  output logic        ram_sel,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_dout,
  output logic        ram_we,
  output logic [15:0] load_end
);

  typedef enum logic [2:0] {IDLE, REQ, WRITE, GAP, PATCH, REL} state_t;

  state_t      state, state_next;
  logic [7:0]  fifo_mem [16];
  logic [3:0]  rd_ptr, wr_ptr;
  logic [4:0]  count, count_next;
  logic        stream_active, stream_next;
  logic        end_seen, loading, patch_pending;
  logic [1:0]  hdr_cnt;
  logic [2:0]  patch_idx;
  logic [15:0] wptr;
  logic [15:0] guard_cnt;
  logic [7:0]  gap_cnt;
  logic        dl_ready_r;
  logic [15:0] load_end_r;

  logic start_ok, end_take, hdr_take, push, pop, done;

  assign start_ok    = dl_start && !loading;
  assign end_take    = dl_end && stream_active;
  assign hdr_take    = dl_wr && dl_ready_r && (hdr_cnt != 2'd2);
  assign push        = dl_wr && dl_ready_r && (hdr_cnt == 2'd2);
  assign pop         = (state == WRITE);
  assign count_next  = count + {4'd0, push} - {4'd0, pop};
  assign stream_next = start_ok ? 1'b1 : (end_take ? 1'b0 : stream_active);
  // Load is finished once the stream ended and nothing is left to write or patch.
  assign done        = loading && end_seen && !patch_pending && (count == 5'd0) &&
                       ((state == IDLE) || (state == REL));

  assign dl_ready = dl_ready_r;
  assign busy     = loading;
  assign load_end = load_end_r;

  always_ff @(posedge CLK28) begin
    if (push) fifo_mem[wr_ptr] <= dl_data;
  end

  always_ff @(posedge CLK28) begin
    if (RESET) begin
      stream_active <= 1'b0;
      end_seen      <= 1'b0;
      loading       <= 1'b0;
      patch_pending <= 1'b0;
      hdr_cnt       <= 2'd0;
      patch_idx     <= 3'd0;
      wptr          <= 16'd0;
      rd_ptr        <= 4'd0;
      wr_ptr        <= 4'd0;
      count         <= 5'd0;
      guard_cnt     <= 16'd0;
      gap_cnt       <= 8'd0;
      dl_ready_r    <= 1'b0;
      load_end_r    <= 16'd0;
    end else begin
      stream_active <= stream_next;
      dl_ready_r    <= stream_next && (count_next < 5'd16);
      count         <= count_next;
      if (push) wr_ptr <= wr_ptr + 4'd1;
      if (pop)  rd_ptr <= rd_ptr + 4'd1;
      guard_cnt <= (state == REQ) ? guard_cnt + 16'd1 : 16'd0;
      gap_cnt   <= (state == GAP) ? gap_cnt + 8'd1 : 8'd0;
      if (start_ok) begin
        loading       <= 1'b1;
        end_seen      <= 1'b0;
        patch_pending <= 1'b0;
        hdr_cnt       <= 2'd0;
        patch_idx     <= 3'd0;
      end else begin
        if (end_take) end_seen <= 1'b1;
        // Header bytes form the load address and never enter the FIFO.
        if (hdr_take) begin
          hdr_cnt <= hdr_cnt + 2'd1;
          if (hdr_cnt == 2'd0) begin
            wptr[7:0] <= dl_data;
          end else begin
            wptr[15:8]    <= dl_data;
            patch_pending <= 1'b1;
          end
        end
        if (pop) wptr <= wptr + 16'd1;
        if (state == PATCH) begin
          patch_idx <= patch_idx + 3'd1;
          if (patch_idx == 3'd5) patch_pending <= 1'b0;
        end
        if (done) begin
          loading <= 1'b0;
          if (state == REL) load_end_r <= wptr;
        end
      end
    end
  end

  always_ff @(posedge CLK28) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if ((count >= 5'(BURST)) || (end_seen && ((count != 5'd0) || patch_pending)))
          state_next = REQ;
      end
      REQ: begin
        if (guard_cnt == 16'(GUARD - 1))
          state_next = (count != 5'd0) ? WRITE : (patch_pending ? PATCH : REL);
      end
      WRITE, PATCH: state_next = GAP;
      GAP: begin
        // A nonzero patch index means the pointer patch sequence is under way.
        if (gap_cnt == 8'(WR_CYCLES - 2)) begin
          if (patch_idx != 3'd0)                state_next = (patch_idx == 3'd6) ? REL : PATCH;
          else if (count != 5'd0)               state_next = WRITE;
          else if (end_seen && patch_pending)   state_next = PATCH;
          else                                  state_next = REL;
        end
      end
      REL:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    wait_cpu = 1'b0;
    ram_sel  = 1'b0;
    ram_we   = 1'b0;
    ram_addr = 16'd0;
    ram_dout = 8'd0;
    case (state)
      REQ: wait_cpu = 1'b1;
      WRITE: begin
        wait_cpu = 1'b1;
        ram_sel  = 1'b1;
        ram_we   = 1'b1;
        ram_addr = wptr;
        ram_dout = fifo_mem[rd_ptr];
      end
      GAP: begin
        wait_cpu = 1'b1;
        ram_sel  = 1'b1;
      end
      PATCH: begin
        wait_cpu = 1'b1;
        ram_sel  = 1'b1;
        ram_we   = 1'b1;
        ram_addr = 16'h002D + {13'd0, patch_idx};
        ram_dout = patch_idx[0] ? wptr[15:8] : wptr[7:0];
      end
      REL: wait_cpu = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_c16_prg_loader.sv
// Randomized bench for c16_prg_loader: a byte-stream model predicts every RAM
// write and the end pointer; a bus monitor checks the WAIT/ram_sel/ram_we timing.
module tb_c16_prg_loader;

  localparam int GUARD     = 64;
  localparam int WR_CYCLES = 4;
  localparam int BURST     = 8;

  logic        CLK28 = 1'b0;
  logic        RESET = 1'b1;
  logic        dl_start = 1'b0, dl_wr = 1'b0, dl_end = 1'b0;
  logic [7:0]  dl_data = 8'd0;
  logic        dl_ready, busy, wait_cpu, ram_sel, ram_we;
  logic [15:0] ram_addr, load_end;
  logic [7:0]  ram_dout;

  always #5 CLK28 = ~CLK28;

  c16_prg_loader #(.GUARD(GUARD), .WR_CYCLES(WR_CYCLES), .BURST(BURST)) dut (
    .CLK28(CLK28), .RESET(RESET), .dl_start(dl_start), .dl_wr(dl_wr),
    .dl_data(dl_data), .dl_end(dl_end), .dl_ready(dl_ready), .busy(busy),
    .wait_cpu(wait_cpu), .ram_sel(ram_sel), .ram_addr(ram_addr),
    .ram_dout(ram_dout), .ram_we(ram_we), .load_end(load_end)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0]  stream_q[$];
  logic [15:0] obs_addr[$];
  logic [7:0]  obs_data[$];
  logic [15:0] exp_addr[$];
  logic [7:0]  exp_data[$];
  logic [15:0] exp_end;

  bit mon_en = 0, prev_wait = 0, prev_sel = 0, wait_fall_due = 0, saw_wait = 0;
  int wait_rise = 0, last_we = -1, first_stall = -1;

  always @(posedge CLK28) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK28) begin
    if (mon_en) begin
      if (wait_cpu) saw_wait = 1;
      if (wait_cpu && !prev_wait) wait_rise = cyc;
      if (ram_sel && !prev_sel) begin
        checkOutput("guard", cyc - wait_rise, GUARD);
        last_we = -1;
      end
      if (wait_fall_due) begin
        checkOutput("wait_fall", {31'd0, wait_cpu}, 0);
        wait_fall_due = 0;
      end
      if (!ram_sel && prev_sel) begin
        checkOutput("sel_before_wait", {31'd0, wait_cpu}, 1);
        wait_fall_due = 1;
      end
      if (ram_we) begin
        checkOutput("we_sel", {31'd0, ram_sel}, 1);
        if (last_we >= 0) checkOutput("we_space", cyc - last_we, WR_CYCLES);
        last_we = cyc;
        obs_addr.push_back(ram_addr);
        obs_data.push_back(ram_dout);
      end
    end
    prev_wait = wait_cpu;
    prev_sel  = ram_sel;
  end

  task automatic clearMon();
    obs_addr.delete();
    obs_data.delete();
    last_we       = -1;
    wait_fall_due = 0;
    saw_wait      = 0;
    first_stall   = -1;
    mon_en        = 1;
  endtask

  // Expected RAM image of a stream: payload at header address onward, then pointer patch.
  task automatic buildModel();
    int n;
    logic [15:0] base;
    n = stream_q.size();
    exp_addr.delete();
    exp_data.delete();
    exp_end = 16'd0;
    if (n >= 2) begin
      base = {stream_q[1], stream_q[0]};
      for (int i = 2; i < n; i++) begin
        exp_addr.push_back(16'(base + (i - 2)));
        exp_data.push_back(stream_q[i]);
      end
      exp_end = 16'(base + (n - 2));
      for (int k = 0; k < 6; k++) begin
        exp_addr.push_back(16'(16'h002D + k));
        exp_data.push_back((k % 2 == 0) ? exp_end[7:0] : exp_end[15:8]);
      end
    end
  endtask

  task automatic startStream();
    dl_start = 1;
    @(negedge CLK28);
    dl_start = 0;
  endtask

  task automatic endStream();
    dl_end = 1;
    @(negedge CLK28);
    dl_end = 0;
  endtask

  task automatic sendBytes(input int gap_max, input int inject_at);
    int n;
    for (int i = 0; i < stream_q.size(); i++) begin
      n = 0;
      while (!dl_ready && n < 5000) begin
        if (i >= 2 && first_stall < 0) first_stall = i - 2;
        @(negedge CLK28);
        n++;
      end
      if (n >= 5000) begin
        checkOutput("ready_timeout", 0, 1);
        return;
      end
      dl_wr   = 1;
      dl_data = stream_q[i];
      if (i == inject_at) dl_start = 1;
      @(negedge CLK28);
      dl_wr    = 0;
      dl_start = 0;
      repeat ($urandom_range(0, gap_max)) @(negedge CLK28);
    end
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy && n < 20000) begin
      @(negedge CLK28);
      n++;
    end
    checkOutput("busy_fall", {31'd0, busy}, 0);
    repeat (3) @(negedge CLK28);
  endtask

  task automatic checkLoad(input string name);
    int m;
    buildModel();
    checkOutput({name, "_nwrites"}, obs_addr.size(), exp_addr.size());
    m = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    for (int i = 0; i < m; i++) begin
      checkOutput($sformatf("%s_addr%0d", name, i), {16'd0, obs_addr[i]}, {16'd0, exp_addr[i]});
      checkOutput($sformatf("%s_data%0d", name, i), {24'd0, obs_data[i]}, {24'd0, exp_data[i]});
    end
    if (stream_q.size() >= 2) checkOutput({name, "_load_end"}, {16'd0, load_end}, {16'd0, exp_end});
    else                      checkOutput({name, "_no_wait"}, {31'd0, saw_wait}, 0);
    checkOutput({name, "_ready_idle"}, {31'd0, dl_ready}, 0);
  endtask

  task automatic applyStimulus(input string name, input int gap_max);
    clearMon();
    startStream();
    sendBytes(gap_max, -1);
    endStream();
    waitIdle();
    checkLoad(name);
  endtask

  task automatic randomStream(input logic [15:0] hdr, input int ndata);
    stream_q.delete();
    stream_q.push_back(hdr[7:0]);
    stream_q.push_back(hdr[15:8]);
    for (int i = 0; i < ndata; i++) stream_q.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    int n;
    repeat (3) @(negedge CLK28);
    checkOutput("rst_ready", {31'd0, dl_ready}, 0);
    checkOutput("rst_busy",  {31'd0, busy}, 0);
    checkOutput("rst_wait",  {31'd0, wait_cpu}, 0);
    checkOutput("rst_sel",   {31'd0, ram_sel}, 0);
    checkOutput("rst_we",    {31'd0, ram_we}, 0);
    checkOutput("rst_addr",  {16'd0, ram_addr}, 0);
    checkOutput("rst_dout",  {24'd0, ram_dout}, 0);
    checkOutput("rst_end",   {16'd0, load_end}, 0);
    RESET = 0;
    @(negedge CLK28);

    stream_q = '{8'h01, 8'h10, 8'hAA, 8'hBB, 8'hCC};
    applyStimulus("basic", 2);

    // Full-rate stream: ready must drop exactly when 16 payload bytes sit in the FIFO.
    randomStream(16'h2000, 18);
    applyStimulus("fullrate", 0);
    checkOutput("ready_drop_at16", first_stall, 16);

    stream_q = '{8'hFE, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h44};
    applyStimulus("wrap", 1);

    stream_q = '{8'h55};
    applyStimulus("short", 1);

    // dl_start while busy, both mid-stream and during the write phase.
    randomStream(16'h3000, 10);
    clearMon();
    startStream();
    sendBytes(0, 5);
    endStream();
    n = 0;
    while (!wait_cpu && n < 500) begin
      @(negedge CLK28);
      n++;
    end
    startStream();
    waitIdle();
    checkLoad("restart_ignored");

    // Reset while a burst is in its gap phase.
    randomStream(16'h4000, 12);
    clearMon();
    startStream();
    sendBytes(0, -1);
    n = 0;
    while (!ram_we && n < 500) begin
      @(negedge CLK28);
      n++;
    end
    checkOutput("rst_mid_we_seen", {31'd0, ram_we}, 1);
    @(negedge CLK28);
    mon_en = 0;
    RESET  = 1;
    @(negedge CLK28);
    checkOutput("rstmid_wait",  {31'd0, wait_cpu}, 0);
    checkOutput("rstmid_sel",   {31'd0, ram_sel}, 0);
    checkOutput("rstmid_we",    {31'd0, ram_we}, 0);
    checkOutput("rstmid_ready", {31'd0, dl_ready}, 0);
    checkOutput("rstmid_busy",  {31'd0, busy}, 0);
    checkOutput("rstmid_end",   {16'd0, load_end}, 0);
    RESET = 0;
    @(negedge CLK28);
    randomStream(16'($urandom_range(0, 65535)), 9);
    applyStimulus("after_reset", 2);

    for (int t = 0; t < 8; t++) begin
      int len;
      len = $urandom_range(0, 30);
      if (len < 2) begin
        stream_q.delete();
        for (int i = 0; i < len; i++) stream_q.push_back(8'($urandom_range(0, 255)));
      end else begin
        randomStream((t % 3 == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15))
                                  : 16'($urandom_range(0, 65535)), len - 2);
      end
      applyStimulus($sformatf("rand%0d", t), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
